// File: rtl/data_mem_responder_if.sv
// Data-memory handshake between the core's memory stage (master) and the responder (slave).
interface data_mem_responder_if;
    logic        request;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        valid;
    logic        stall;

    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, stall
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: latches one request, waits LATENCY edges,
// commits byte-masked stores or returns the aligned word with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | no access in flight; a request is accepted at the next edge
// WAIT  | access latched, counting down remaining wait cycles
// RESP  | valid cycle; returns to IDLE unconditionally
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_responder_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            latch_en;
    logic            commit;

    logic [AW-1:0]   idx_q;
    logic            we_q;
    logic [3:0]      mask_q;
    logic [31:0]     data_q;

    logic [AW-1:0]   c_idx;
    logic            c_we;
    logic [3:0]      c_mask;
    logic [31:0]     c_data;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     load_data_q;
    logic            valid_q;

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:AW+2], bus.address[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.request) begin
                    latch_en = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the accepting edge, so use the live inputs.
    always_comb begin
        c_idx  = latch_en ? bus.address[AW+1:2] : idx_q;
        c_we   = latch_en ? bus.we_re           : we_q;
        c_mask = latch_en ? bus.mask            : mask_q;
        c_data = latch_en ? bus.store_data      : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            valid_q     <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            valid_q     <= commit;
            load_data_q <= (commit && !c_we) ? mem[c_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            idx_q  <= bus.address[AW+1:2];
            we_q   <= bus.we_re;
            mask_q <= bus.mask;
            data_q <= bus.store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && c_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_mask[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    assign bus.load_data = load_data_q;
    assign bus.valid     = valid_q;
    assign bus.stall     = ((state == IDLE) && bus.request) || (state == WAIT);
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=1 and LATENCY=4 instances checked every cycle
// against a timeline model, plus directed literal expectations.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0]  v_s, st_s, req_s, we_s;
    logic [3:0]  mk_s [2];
    logic [31:0] ad_s [2];
    logic [31:0] sd_s [2];
    logic [31:0] ld_s [2];
    assign v_s   = {bus1.valid,   bus0.valid};
    assign st_s  = {bus1.stall,   bus0.stall};
    assign req_s = {bus1.request, bus0.request};
    assign we_s  = {bus1.we_re,   bus0.we_re};
    assign mk_s[0] = bus0.mask;       assign mk_s[1] = bus1.mask;
    assign ad_s[0] = bus0.address;    assign ad_s[1] = bus1.address;
    assign sd_s[0] = bus0.store_data; assign sd_s[1] = bus1.store_data;
    assign ld_s[0] = bus0.load_data;  assign ld_s[1] = bus1.load_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timeline model: an access accepted at the end of cycle c responds in cycle c+LATENCY.
    int          lat [2] = '{1, 4};
    logic [31:0] mmem [2][1024];
    bit          pend [2];
    int          rc [2];
    logic        p_we [2];
    logic [3:0]  p_mask [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    logic [31:0] rdata [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                bit idle, in_resp, in_wait;
                int wi;
                idle    = !pend[d];
                in_resp = pend[d] && (cyc == rc[d]);
                in_wait = pend[d] && (cyc < rc[d]);
                check($sformatf("d%0d valid c%0d", d, cyc), {31'd0, v_s[d]}, {31'd0, in_resp});
                check($sformatf("d%0d stall c%0d", d, cyc), {31'd0, st_s[d]},
                      {31'd0, in_wait || (idle && req_s[d])});
                check($sformatf("d%0d load_data c%0d", d, cyc), ld_s[d], in_resp ? rdata[d] : 32'd0);
                if (rst) begin
                    pend[d] = 1'b0;
                end else begin
                    if (in_resp) pend[d] = 1'b0;
                    if (idle && req_s[d]) begin
                        pend[d]   = 1'b1;
                        rc[d]     = cyc + lat[d];
                        p_we[d]   = we_s[d];
                        p_mask[d] = mk_s[d];
                        p_addr[d] = ad_s[d];
                        p_data[d] = sd_s[d];
                    end
                    if (pend[d] && (cyc + 1 == rc[d])) begin
                        wi = int'((p_addr[d] >> 2) % 1024);
                        if (p_we[d]) begin
                            for (int b = 0; b < 4; b++)
                                if (p_mask[d][b]) mmem[d][wi][8*b +: 8] = p_data[d][8*b +: 8];
                            rdata[d] = 32'd0;
                        end else begin
                            rdata[d] = mmem[d][wi];
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input logic req, input logic we, input logic [3:0] mk,
                         input logic [31:0] addr, input logic [31:0] data);
        if (d == 0) begin
            bus0.request = req; bus0.we_re = we; bus0.mask = mk;
            bus0.address = addr; bus0.store_data = data;
        end else begin
            bus1.request = req; bus1.we_re = we; bus1.mask = mk;
            bus1.address = addr; bus1.store_data = data;
        end
    endtask

    // Core-side access: hold request until the valid cycle, retire at the end of it.
    task automatic do_access(input int d, input logic we, input logic [3:0] mk,
                             input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] got, output int scnt, output int vcnt);
        bit done;
        done = 1'b0; scnt = 0; vcnt = 0; got = 32'hxxxx_xxxx;
        @(posedge clk); #1;
        drive(d, 1'b1, we, mk, addr, data);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (st_s[d]) scnt++;
            if (v_s[d]) begin vcnt++; got = ld_s[d]; done = 1'b1; end
        end
        if (!done) check($sformatf("d%0d access timeout", d), 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (v_s[d]) vcnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int scnt, vcnt, vab;
        for (int w = 0; w < 1024; w++) begin mmem[0][w] = 32'd0; mmem[1][w] = 32'd0; end
        pend = '{1'b0, 1'b0};
        rdata = '{32'd0, 32'd0};
        drive(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("reset valid0", {31'd0, v_s[0]}, 32'd0);
        check("reset valid1", {31'd0, v_s[1]}, 32'd0);
        check("reset stall",  {30'd0, st_s}, 32'd0);
        check("reset load_data1", ld_s[1], 32'd0);

        do_access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, got, scnt, vcnt);
        check("l1 store resp data", got, 32'd0);
        check("l1 store stall cycles", scnt, 1);
        check("l1 store valid pulses", vcnt, 1);
        do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, got, scnt, vcnt);
        check("l1 load 0x10", got, 32'hDEADBEEF);
        check("l1 load stall cycles", scnt, 1);

        do_access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, got, scnt, vcnt);
        do_access(0, 1'b1, 4'h4, 32'h20, 32'h00AA0000, got, scnt, vcnt);
        do_access(0, 1'b0, 4'h0, 32'h20, 32'h0, got, scnt, vcnt);
        check("partial store", got, 32'h11AA3344);

        do_access(0, 1'b1, 4'h0, 32'h10, 32'h12345678, got, scnt, vcnt);
        check("mask0 store valid pulses", vcnt, 1);
        do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, got, scnt, vcnt);
        check("mask0 leaves word", got, 32'hDEADBEEF);

        do_access(0, 1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, got, scnt, vcnt);
        do_access(0, 1'b0, 4'h0, 32'h0, 32'h0, got, scnt, vcnt);
        check("wrap load 0x0", got, 32'h5A5A5A5A);
        do_access(0, 1'b0, 4'h0, 32'h3, 32'h0, got, scnt, vcnt);
        check("low bits ignored", got, 32'h5A5A5A5A);

        do_access(1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D, got, scnt, vcnt);
        do_access(1, 1'b0, 4'h0, 32'h30, 32'h0, got, scnt, vcnt);
        check("l4 load 0x30", got, 32'hCAFEF00D);
        check("l4 stall cycles", scnt, 4);
        check("l4 single valid", vcnt, 1);

        do_access(1, 1'b1, 4'hF, 32'h40, 32'h0, got, scnt, vcnt);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
        vab = 0;
        @(negedge clk); if (v_s[1]) vab++;
        @(negedge clk); if (v_s[1]) vab++;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk); if (v_s[1]) vab++;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (v_s[1]) vab++;
        end
        check("aborted store valid pulses", vab, 0);
        do_access(1, 1'b0, 4'h0, 32'h40, 32'h0, got, scnt, vcnt);
        check("aborted store dropped", got, 32'h0);

        do_access(0, 1'b1, 4'hF, 32'h50, 32'h0BADF00D, got, scnt, vcnt);
        check("store resp load_data zero", got, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle valid %0d", i), {30'd0, v_s}, 32'd0);
            check($sformatf("idle stall %0d", i), {30'd0, st_s}, 32'd0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
